mc_sequencer: RTL and testbench

Multicycle control sequencer that drives the 16-bit control word consumed by the 32-bit multicycle datapath. It watches the six instruction-register opcode bits, steps a Moore state machine through fetch, decode, execute, memory and write-back, and gives each step's mux selects and write enables to the datapath. It also keeps a retired-instruction count and a sticky halt flag for bench and debug use.

---
 rtl/mc_ctrl_pkg.sv | 75 +++++++
 rtl/mc_ctrl_decode.sv | 70 +++++++
 rtl/mc_sequencer.sv | 110 +++++++++++
 tb/tb_mc_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control sequencer: state encoding,
// opcode classes, control-word bit positions and the named select values.
package mc_ctrl_pkg;

    localparam int CTRL_W = 16;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    // Instruction class from IR[31:30]
    localparam logic [1:0] CLS_R    = 2'b00;
    localparam logic [1:0] CLS_I    = 2'b01;
    localparam logic [1:0] CLS_MEM  = 2'b10;
    localparam logic [1:0] CLS_CTRL = 2'b11;

    // Control subclass from IR[27:26]
    localparam logic [1:0] SUB_BNE  = 2'b00;
    localparam logic [1:0] SUB_J    = 2'b01;
    localparam logic [1:0] SUB_RSVD = 2'b10;
    localparam logic [1:0] SUB_HALT = 2'b11;

    // Bit positions within the control word, MSB first
    localparam int B_PCWRITECOND = 15;
    localparam int B_PCWRITE     = 14;
    localparam int B_IORD        = 13;
    localparam int B_MEMREAD     = 12;
    localparam int B_MEMWRITE    = 11;
    localparam int B_MEMTOREG    = 10;
    localparam int B_IRWRITE     = 9;
    localparam int B_PCSRC_LO    = 7;
    localparam int B_ALUOP_LO    = 5;
    localparam int B_ALUSRCB_LO  = 3;
    localparam int B_ALUSRCA     = 2;
    localparam int B_REGWRITE    = 1;
    localparam int B_REGDST      = 0;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_REG2 = 2'b10;

    localparam logic [1:0] ALUOP_INC  = 2'b00;
    localparam logic [1:0] ALUOP_FUNC = 2'b01;
    localparam logic [1:0] ALUOP_BR   = 2'b10;
    localparam logic [1:0] ALUOP_ADD  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Write enables suppressed while stalled; selects and MemRead pass through
    localparam logic [CTRL_W-1:0] ENABLE_MASK = CTRL_W'((1 << B_PCWRITECOND) |
                                                        (1 << B_PCWRITE)     |
                                                        (1 << B_MEMWRITE)    |
                                                        (1 << B_IRWRITE)     |
                                                        (1 << B_REGWRITE));

    function automatic logic is_last_state(input state_e s);
        return (s == S_WB_R) || (s == S_WB_I) || (s == S_MEM_WB) ||
               (s == S_MEM_WR) || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure Moore map from sequencer state to the 16-bit datapath control word.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e            state_i,
    output logic [CTRL_W-1:0] word_o
);

    always_comb begin
        word_o = '0;
        case (state_i)
            S_FETCH: begin
                word_o[B_IRWRITE]              = 1'b1;
                word_o[B_PCWRITE]              = 1'b1;
                word_o[B_ALUOP_LO +: 2]        = ALUOP_INC;
                word_o[B_PCSRC_LO +: 2]        = PCSRC_ALU;
            end
            S_DECODE: begin
                word_o[B_ALUSRCB_LO +: 2]      = SRCB_IMM;
                word_o[B_ALUOP_LO +: 2]        = ALUOP_ADD;
            end
            S_EXEC_R: begin
                word_o[B_ALUSRCA]              = 1'b1;
                word_o[B_ALUSRCB_LO +: 2]      = SRCB_B;
                word_o[B_ALUOP_LO +: 2]        = ALUOP_FUNC;
            end
            S_WB_R: begin
                word_o[B_REGWRITE]             = 1'b1;
            end
            S_EXEC_I: begin
                word_o[B_ALUSRCA]              = 1'b1;
                word_o[B_ALUSRCB_LO +: 2]      = SRCB_IMM;
                word_o[B_ALUOP_LO +: 2]        = ALUOP_FUNC;
            end
            S_WB_I: begin
                word_o[B_REGWRITE]             = 1'b1;
                word_o[B_REGDST]               = 1'b1;
            end
            S_MEM_ADDR: begin
                word_o[B_ALUSRCA]              = 1'b1;
                word_o[B_ALUSRCB_LO +: 2]      = SRCB_IMM;
                word_o[B_ALUOP_LO +: 2]        = ALUOP_ADD;
            end
            S_MEM_RD: begin
                word_o[B_MEMREAD]              = 1'b1;
            end
            S_MEM_WB: begin
                word_o[B_REGWRITE]             = 1'b1;
                word_o[B_REGDST]               = 1'b1;
                word_o[B_MEMTOREG]             = 1'b1;
            end
            S_MEM_WR: begin
                word_o[B_MEMWRITE]             = 1'b1;
            end
            S_BRANCH: begin
                word_o[B_ALUSRCA]              = 1'b1;
                word_o[B_ALUSRCB_LO +: 2]      = SRCB_REG2;
                word_o[B_ALUOP_LO +: 2]        = ALUOP_BR;
                word_o[B_PCWRITECOND]          = 1'b1;
                word_o[B_PCSRC_LO +: 2]        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                word_o[B_PCWRITE]              = 1'b1;
                word_o[B_PCSRC_LO +: 2]        = PCSRC_JUMP;
            end
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: Moore FSM over fetch/decode/execute/memory/
// write-back, with stall and reset gating, retired-instruction counter and halt flag.
module mc_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            input_signal,
    input  logic                  stall,
    output logic [15:0]           output_signal,
    output logic [STATE_W-1:0]    state_out,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] instr_count
);

    state_e                  state_q, state_d;
    logic                    is_sw_q, is_sw_d;
    logic                    halted_q, halted_d;
    logic [DATA_WIDTH-1:0]   count_q, count_d;
    logic                    retire;
    logic [CTRL_W-1:0]       word;

    logic [1:0] op_class;
    logic [1:0] op_sub;
    assign op_class = input_signal[5:4];
    assign op_sub   = input_signal[1:0];

    // IR[29:28] carry no control meaning for this sequencer
    logic unused_ir_bits;
    assign unused_ir_bits = &{1'b0, input_signal[3:2]};

    always_comb begin
        state_d = state_q;
        is_sw_d = is_sw_q;
        retire  = 1'b0;
        if (!stall) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    // The LW/SW choice is captured here so MEM_ADDR needs no IR
                    is_sw_d = input_signal[0];
                    case (op_class)
                        CLS_R:   state_d = S_EXEC_R;
                        CLS_I:   state_d = S_EXEC_I;
                        CLS_MEM: state_d = S_MEM_ADDR;
                        default: begin
                            case (op_sub)
                                SUB_BNE:  state_d = S_BRANCH;
                                SUB_J:    state_d = S_JUMP;
                                SUB_HALT: state_d = S_HALT;
                                default: begin
                                    state_d = S_FETCH;
                                    retire  = 1'b1;
                                end
                            endcase
                        end
                    endcase
                end
                S_EXEC_R:   state_d = S_WB_R;
                S_EXEC_I:   state_d = S_WB_I;
                S_MEM_ADDR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   state_d = S_MEM_WB;
                S_HALT:     state_d = S_HALT;
                default:    state_d = S_FETCH;
            endcase
            if (is_last_state(state_q)) begin
                retire = 1'b1;
            end
        end
    end

    assign count_d  = retire ? count_q + DATA_WIDTH'(1) : count_q;
    assign halted_d = halted_q | (state_d == S_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            is_sw_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            is_sw_q  <= is_sw_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i (state_q),
        .word_o  (word)
    );

    always_comb begin
        output_signal = word;
        if (reset) begin
            output_signal = '0;
        end else if (stall) begin
            output_signal = word & ~ENABLE_MASK;
        end
    end

    assign state_out   = STATE_W'(state_q);
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: walks each instruction class, stall, halt and reset.
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  input_signal;
    logic        stall;
    logic [15:0] output_signal;
    logic [3:0]  state_out;
    logic        halted;
    logic [31:0] instr_count;

    int vec_cnt = 0;
    int miscompare_cnt = 0;

    // Expected control words, hand-assembled from the field layout
    localparam logic [15:0] W_FETCH    = 16'h4200;
    localparam logic [15:0] W_DECODE   = 16'h0068;
    localparam logic [15:0] W_EXEC_R   = 16'h0024;
    localparam logic [15:0] W_WB_R     = 16'h0002;
    localparam logic [15:0] W_EXEC_I   = 16'h002C;
    localparam logic [15:0] W_WB_I     = 16'h0003;
    localparam logic [15:0] W_MEM_ADDR = 16'h006C;
    localparam logic [15:0] W_MEM_RD   = 16'h1000;
    localparam logic [15:0] W_MEM_WB   = 16'h0403;
    localparam logic [15:0] W_MEM_WR   = 16'h0800;
    localparam logic [15:0] W_BRANCH   = 16'h80D4;
    localparam logic [15:0] W_JUMP     = 16'h4100;

    always #5 clk = ~clk;

    mc_sequencer #(.DATA_WIDTH(32), .STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .input_signal  (input_signal),
        .stall         (stall),
        .output_signal (output_signal),
        .state_out     (state_out),
        .halted        (halted),
        .instr_count   (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Check current state and word, then advance one clock
    task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] w);
        chk({tag, ".state"}, 32'(state_out), 32'(st));
        chk({tag, ".word"}, 32'(output_signal), 32'(w));
        step();
    endtask

    task automatic end_instr(input string name, input logic [31:0] cnt);
        chk({name, ".ret_state"}, 32'(state_out), 32'd0);
        chk({name, ".count"}, instr_count, cnt);
        $display("instr %s retired, instr_count=%0d", name, instr_count);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        input_signal = 6'b000000;
        repeat (3) step();
        chk("rst.word", 32'(output_signal), 32'h0);
        chk("rst.state", 32'(state_out), 32'd0);
        chk("rst.count", instr_count, 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        reset = 1'b0;
        #1;

        // R-type
        input_signal = 6'b000010;
        cyc("R.fetch", 4'd0, W_FETCH);
        cyc("R.decode", 4'd1, W_DECODE);
        cyc("R.exec", 4'd2, W_EXEC_R);
        cyc("R.wb", 4'd3, W_WB_R);
        end_instr("R", 32'd1);

        // LW
        input_signal = 6'b100000;
        cyc("LW.fetch", 4'd0, W_FETCH);
        cyc("LW.decode", 4'd1, W_DECODE);
        cyc("LW.addr", 4'd6, W_MEM_ADDR);
        cyc("LW.rd", 4'd7, W_MEM_RD);
        cyc("LW.wb", 4'd8, W_MEM_WB);
        end_instr("LW", 32'd2);

        // SW
        input_signal = 6'b100001;
        cyc("SW.fetch", 4'd0, W_FETCH);
        cyc("SW.decode", 4'd1, W_DECODE);
        cyc("SW.addr", 4'd6, W_MEM_ADDR);
        cyc("SW.wr", 4'd9, W_MEM_WR);
        end_instr("SW", 32'd3);

        // BNE
        input_signal = 6'b110000;
        cyc("BNE.fetch", 4'd0, W_FETCH);
        cyc("BNE.decode", 4'd1, W_DECODE);
        cyc("BNE.branch", 4'd10, W_BRANCH);
        end_instr("BNE", 32'd4);

        // J
        input_signal = 6'b110001;
        cyc("J.fetch", 4'd0, W_FETCH);
        cyc("J.decode", 4'd1, W_DECODE);
        cyc("J.jump", 4'd11, W_JUMP);
        end_instr("J", 32'd5);

        // Reserved control opcode retires as a 2-cycle NOP
        input_signal = 6'b110010;
        cyc("NOP.fetch", 4'd0, W_FETCH);
        cyc("NOP.decode", 4'd1, W_DECODE);
        end_instr("NOP", 32'd6);

        // Stall in FETCH masks IRWrite and PCWrite
        stall = 1'b1;
        #1;
        chk("stF.word", 32'(output_signal), 32'h0);
        step();
        chk("stF.state", 32'(state_out), 32'd0);
        stall = 1'b0;
        #1;

        // I-type with 5-cycle stall in EXEC_I
        input_signal = 6'b010000;
        cyc("I.fetch", 4'd0, W_FETCH);
        cyc("I.decode", 4'd1, W_DECODE);
        stall = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("I.st.state", 32'(state_out), 32'd4);
            chk("I.st.word", 32'(output_signal), 32'(W_EXEC_I));
            chk("I.st.count", instr_count, 32'd6);
            step();
        end
        stall = 1'b0;
        #1;
        cyc("I.exec", 4'd4, W_EXEC_I);
        cyc("I.wb", 4'd5, W_WB_I);
        end_instr("I", 32'd7);

        // Stall while in WB_I-like last state must mask RegWrite and hold count
        input_signal = 6'b010000;
        cyc("I2.fetch", 4'd0, W_FETCH);
        cyc("I2.decode", 4'd1, W_DECODE);
        cyc("I2.exec", 4'd4, W_EXEC_I);
        stall = 1'b1;
        #1;
        chk("I2.stwb.word", 32'(output_signal), 32'h0001);
        step();
        chk("I2.stwb.count", instr_count, 32'd7);
        chk("I2.stwb.state", 32'(state_out), 32'd5);
        stall = 1'b0;
        #1;
        cyc("I2.wb", 4'd5, W_WB_I);
        end_instr("I2", 32'd8);

        // HALT
        input_signal = 6'b111111;
        cyc("H.fetch", 4'd0, W_FETCH);
        chk("H.dec.halted", 32'(halted), 32'd0);
        cyc("H.decode", 4'd1, W_DECODE);
        for (int i = 0; i < 4; i++) begin
            chk("H.halted", 32'(halted), 32'd1);
            chk("H.count", instr_count, 32'd8);
            cyc("H.idle", 4'd12, 16'h0000);
        end
        $display("instr HALT entered, halted=%0d instr_count=%0d", halted, instr_count);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("H.rst.halted", 32'(halted), 32'd0);
        chk("H.rst.count", instr_count, 32'd0);

        // Reset pulsed in MEM_WB abandons the load
        input_signal = 6'b100000;
        cyc("RL.fetch", 4'd0, W_FETCH);
        cyc("RL.decode", 4'd1, W_DECODE);
        cyc("RL.addr", 4'd6, W_MEM_ADDR);
        cyc("RL.rd", 4'd7, W_MEM_RD);
        chk("RL.wb.state", 32'(state_out), 32'd8);
        reset = 1'b1;
        stall = 1'b1;
        #1;
        chk("RL.rst.word", 32'(output_signal), 32'h0);
        step();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        chk("RL.after.state", 32'(state_out), 32'd0);
        chk("RL.after.word", 32'(output_signal), 32'(W_FETCH));
        chk("RL.after.count", instr_count, 32'd0);
        $display("instr LW abandoned by reset, instr_count=%0d", instr_count);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
